// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Tracks in-flight register writes across DEPTH downstream pipeline stages
//   and produces per-read-port forwarding selects plus a load-use stall.
//   Sits beside decode: issue-stage requests come in, and mux selects and a
//   stall go out to the datapath and PC control.
//
// Ports
//   clk         clock
//   rst         asynchronous, active-low reset
//   en          pipeline advance enable; low freezes all state
//   flush       squash the instruction currently at issue
//   rd_addr     read addresses, port i at [i*AW +: AW]
//   rd_used     port i actually consumes its operand
//   wr_addr     destination of the issuing instruction
//   wr_en       issuing instruction writes the register file
//   wr_is_load  issuing instruction is a memory load
//   fwd_sel     per port at [i*SW +: SW]: 0 = register file, k = stage k
//   stall       hold issue/PC this cycle
//   stall_cnt   number of cycles that advanced while stalled (wraps)
//
// Interface timing: fwd_sel and stall are purely combinational from the
// tracker state and the current issue inputs. The tracker advances on a
// clk edge only when en is high. While stall is high the issuing
// instruction is not captured (a bubble is inserted) and must be presented
// again on the following cycle.
module hazard_forward_unit #(
  parameter int NUM_RD   = 2,
  parameter int DEPTH    = 2,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int SW       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 flush,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  input  logic [NUM_RD-1:0]    rd_used,
  input  logic [AW-1:0]        wr_addr,
  input  logic                 wr_en,
  input  logic                 wr_is_load,
  output logic [NUM_RD*SW-1:0] fwd_sel,
  output logic                 stall,
  output logic [31:0]          stall_cnt
);

  // Stage k (1 = nearest to issue) holds {valid, addr, load}.
  logic [DEPTH:1]  r_valid;
  logic [DEPTH:1]  r_load;
  logic [AW-1:0]   r_addr [1:DEPTH];
  logic [31:0]     r_stall_cnt;

  logic [NUM_RD*SW-1:0] w_fwd_sel;
  logic                 w_stall_raw;
  logic                 w_stall;
  logic                 w_cap_valid;
  logic                 w_match;

  // Register 0 is hard-wired, so a write to it is never tracked; this is
  // what guarantees r0 reads never match.
  assign w_cap_valid = wr_en && (wr_addr != '0);

  always_comb begin
    w_fwd_sel   = '0;
    w_stall_raw = 1'b0;
    w_match     = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      // Walk from the oldest stage to the nearest so the nearest producer
      // overwrites older ones and wins.
      for (int k = DEPTH; k >= 1; k--) begin
        w_match = rd_used[i] && r_valid[k] &&
                  (r_addr[k] == rd_addr[i*AW +: AW]);
        if (w_match) begin
          w_fwd_sel[i*SW +: SW] = SW'(k);
          // A load still inside stages 1..LOAD_LAT has no data yet.
          if (r_load[k] && (k <= LOAD_LAT)) begin
            w_stall_raw = 1'b1;
          end
        end
      end
    end
  end

  // A squashed instruction has no operands to wait for.
  assign w_stall   = w_stall_raw && !flush;
  assign fwd_sel   = w_fwd_sel;
  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= '0;
      r_load      <= '0;
      r_stall_cnt <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        r_addr[k] <= '0;
      end
    end else if (en) begin
      for (int k = DEPTH; k >= 2; k--) begin
        r_valid[k] <= r_valid[k-1];
        r_load[k]  <= r_load[k-1];
        r_addr[k]  <= r_addr[k-1];
      end
      if (flush || w_stall) begin
        // Bubble: the issuing instruction is either squashed or re-presented.
        r_valid[1] <= 1'b0;
        r_load[1]  <= 1'b0;
        r_addr[1]  <= '0;
      end else begin
        r_valid[1] <= w_cap_valid;
        r_load[1]  <= wr_is_load;
        r_addr[1]  <= wr_addr;
      end
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  localparam int NUM_RD   = 2;
  localparam int DEPTH    = 2;
  localparam int AW       = 5;
  localparam int LOAD_LAT = 1;
  localparam int SW       = 2;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic                 flush;
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD-1:0]    rd_used;
  logic [AW-1:0]        wr_addr;
  logic                 wr_en;
  logic                 wr_is_load;
  logic [NUM_RD*SW-1:0] fwd_sel;
  logic                 stall;
  logic [31:0]          stall_cnt;

  int checks;
  int failures;

  hazard_forward_unit #(
    .NUM_RD(NUM_RD), .DEPTH(DEPTH), .AW(AW), .LOAD_LAT(LOAD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .rd_addr(rd_addr), .rd_used(rd_used),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_is_load(wr_is_load),
    .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one issue-stage instruction, then let combinational outputs settle.
  task automatic issue(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                       input logic [1:0] used, input logic [AW-1:0] wa,
                       input logic we, input logic wl);
    rd_addr    = {r1, r0};
    rd_used    = used;
    wr_addr    = wa;
    wr_en      = we;
    wr_is_load = wl;
    #1;
  endtask

  task automatic nop();
    issue(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; flush = 1'b0;
    nop();
    step();
    checks++;
    if (fwd_sel !== 4'b0000 || stall !== 1'b0 || stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset: fwd_sel=%b stall=%b cnt=%0d expected 0000 0 0", fwd_sel, stall, stall_cnt);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_forward_age();
    issue(5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0);   // wr r3 (ALU)
    step();
    issue(5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);   // read r3 on port 0
    checks++;
    if (fwd_sel[1:0] !== 2'd1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL fwd_stage1: sel0=%0d stall=%b expected 1 0", fwd_sel[1:0], stall);
    end
    step();
    checks++;
    if (fwd_sel[1:0] !== 2'd2) begin
      failures++;
      $display("FAIL fwd_stage2: sel0=%0d expected 2", fwd_sel[1:0]);
    end
    step();
    checks++;
    if (fwd_sel[1:0] !== 2'd0) begin
      failures++;
      $display("FAIL fwd_retired: sel0=%0d expected 0", fwd_sel[1:0]);
    end
    drain();
  endtask

  task automatic test_nearest_wins();
    issue(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
    step();
    issue(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
    step();
    issue(5'd0, 5'd5, 2'b10, 5'd0, 1'b0, 1'b0);   // read r5 on port 1
    checks++;
    if (fwd_sel[3:2] !== 2'd1 || fwd_sel[1:0] !== 2'd0) begin
      failures++;
      $display("FAIL nearest_wins: sel=%b expected 0100", fwd_sel);
    end
    drain();
  endtask

  task automatic test_load_use();
    issue(5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);   // lw r7
    step();
    issue(5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL load_use_stall: stall=%b expected 1", stall);
    end
    step();
    checks++;
    if (stall_cnt !== 32'd1) begin
      failures++;
      $display("FAIL load_use_cnt: cnt=%0d expected 1", stall_cnt);
    end
    checks++;
    if (stall !== 1'b0 || fwd_sel[1:0] !== 2'd2) begin
      failures++;
      $display("FAIL load_use_after: stall=%b sel0=%0d expected 0 2", stall, fwd_sel[1:0]);
    end
    step();
    checks++;
    if (stall_cnt !== 32'd1) begin
      failures++;
      $display("FAIL load_use_single: cnt=%0d expected 1", stall_cnt);
    end
    drain();
  endtask

  task automatic test_reg_zero_and_unused();
    issue(5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0);   // wr r0
    step();
    issue(5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0);
    checks++;
    if (fwd_sel !== 4'b0000 || stall !== 1'b0) begin
      failures++;
      $display("FAIL reg_zero: sel=%b stall=%b expected 0000 0", fwd_sel, stall);
    end
    drain();
    issue(5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1);   // lw r9
    step();
    issue(5'd9, 5'd9, 2'b00, 5'd0, 1'b0, 1'b0);   // addresses match, not used
    checks++;
    if (fwd_sel !== 4'b0000 || stall !== 1'b0) begin
      failures++;
      $display("FAIL unused_port: sel=%b stall=%b expected 0000 0", fwd_sel, stall);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    issue(5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b0);
    step();
    issue(5'd6, 5'd6, 2'b11, 5'd0, 1'b0, 1'b0);
    checks++;
    if (fwd_sel !== 4'b0101) begin
      failures++;
      $display("FAIL same_reg_ports: sel=%b expected 0101", fwd_sel);
    end
    drain();
  endtask

  task automatic test_freeze_flush();
    issue(5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0);   // wr r4
    step();
    en = 1'b0;
    issue(5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (fwd_sel[1:0] !== 2'd1 || stall_cnt !== 32'd1) begin
        failures++;
        $display("FAIL freeze_%0d: sel0=%0d cnt=%0d expected 1 1", c, fwd_sel[1:0], stall_cnt);
      end
    end
    en = 1'b1;
    flush = 1'b1;
    issue(5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);   // lw r7 squashed
    step();
    flush = 1'b0;
    issue(5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
    checks++;
    if (fwd_sel[1:0] !== 2'd0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_capture: sel0=%0d stall=%b expected 0 0", fwd_sel[1:0], stall);
    end
    drain();
    issue(5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 1'b1);   // lw r8
    step();
    flush = 1'b1;
    issue(5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_over_stall: stall=%b expected 0", stall);
    end
    step();
    flush = 1'b0;
    checks++;
    if (stall_cnt !== 32'd1) begin
      failures++;
      $display("FAIL flush_no_count: cnt=%0d expected 1", stall_cnt);
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    issue(5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 1'b1);  // lw r10
    step();
    issue(5'd10, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_stall: stall=%b expected 1", stall);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (fwd_sel !== 4'b0000 || stall !== 1'b0 || stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: sel=%b stall=%b cnt=%0d expected 0000 0 0", fwd_sel, stall, stall_cnt);
    end
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (fwd_sel !== 4'b0000 || stall !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: sel=%b stall=%b expected 0000 0", fwd_sel, stall);
    end
    drain();
  endtask

  task automatic test_counter_wrap();
    en = 1'b0;
    step();
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    en = 1'b1;
    issue(5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b1);  // lw r11
    step();
    issue(5'd11, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
    step();
    checks++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL cnt_max: cnt=%h expected ffffffff", stall_cnt);
    end
    issue(5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 1'b1);  // lw r12
    step();
    issue(5'd0, 5'd12, 2'b10, 5'd0, 1'b0, 1'b0);
    step();
    checks++;
    if (stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL cnt_wrap: cnt=%h expected 00000000", stall_cnt);
    end
    drain();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b0; en = 1'b0; flush = 1'b0;
    rd_addr = '0; rd_used = '0; wr_addr = '0; wr_en = 1'b0; wr_is_load = 1'b0;
    test_reset();
    test_forward_age();
    test_nearest_wins();
    test_load_use();
    test_reg_zero_and_unused();
    test_back_to_back();
    test_freeze_flush();
    test_reset_midstream();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
